// File: rtl/i2c_bus_arbiter_if.sv
// Bundle of client-side and I2C-master-side signals shared through the arbiter.
// The arbiter uses the master modport; clients, the I2C engine and observers use slave.
interface i2c_bus_arbiter_if;
  logic       req0, req1;
  logic       start0, start1;
  logic       send0, send1;
  logic       receive0, receive1;
  logic [7:0] datasend0, datasend1;
  logic       gnt0, gnt1;
  logic       isReady0, isReady1;
  logic       sended0, sended1;
  logic       received0, received1;
  logic [7:0] datareceive0, datareceive1;
  logic       m_isReady;
  logic       m_start, m_send, m_receive;
  logic [7:0] m_datasend;
  logic       m_sended, m_received;
  logic [7:0] m_datareceive;
  logic       timeout;
  logic [1:0] state;

  modport master (
    input  req0, req1, start0, start1, send0, send1, receive0, receive1,
           datasend0, datasend1, m_isReady, m_sended, m_received, m_datareceive,
    output gnt0, gnt1, isReady0, isReady1, sended0, sended1, received0, received1,
           datareceive0, datareceive1, m_start, m_send, m_receive, m_datasend,
           timeout, state
  );

  modport slave (
    output req0, req1, start0, start1, send0, send1, receive0, receive1,
           datasend0, datasend1, m_isReady, m_sended, m_received, m_datareceive,
    input  gnt0, gnt1, isReady0, isReady1, sended0, sended1, received0, received1,
           datareceive0, datareceive1, m_start, m_send, m_receive, m_datasend,
           timeout, state
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin two-client arbiter for one I2C master port, with a grant watchdog.
//   state   | meaning
//   IDLE    | no grant; waiting for m_isReady and an eligible request
//   GRANT   | one client owns the master; watchdog counting
//   RELEASE | grant dropped; waiting for the master to report ready
module i2c_bus_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input logic clk,
  input logic reset,
  i2c_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arbState_e;

  arbState_e   stateQ, stateD;
  logic        gnt0Q, gnt1Q;
  logic        timeoutQ;
  logic        lastQ;
  logic        blk0Q, blk1Q;
  logic [15:0] countQ;

  logic        elig0, elig1, pick1, ownerReq, wdFire;
  logic        doGrant, doRelease, doTimeout;
  logic        mStart, mSend, mReceive;
  logic [7:0]  mDatasend;

  assign elig0    = bus.req0 & ~blk0Q;
  assign elig1    = bus.req1 & ~blk1Q;
  // On a tie the client that was not served last wins.
  assign pick1    = elig1 & (~elig0 | ~lastQ);
  assign ownerReq = gnt1Q ? bus.req1 : bus.req0;
  assign wdFire   = (TIMEOUT != 16'd0) && (countQ == TIMEOUT - 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ   <= IDLE;
      gnt0Q    <= 1'b0;
      gnt1Q    <= 1'b0;
      timeoutQ <= 1'b0;
      lastQ    <= 1'b1;
      blk0Q    <= 1'b0;
      blk1Q    <= 1'b0;
      countQ   <= 16'd0;
    end else begin
      stateQ   <= stateD;
      timeoutQ <= doTimeout;
      if (doGrant) begin
        gnt0Q  <= ~pick1;
        gnt1Q  <= pick1;
        countQ <= 16'd0;
      end else if (doRelease) begin
        gnt0Q  <= 1'b0;
        gnt1Q  <= 1'b0;
        lastQ  <= gnt1Q;
      end else if (stateQ == GRANT) begin
        countQ <= countQ + 16'd1;
      end
      // A timed-out client stays blocked until it lets go of its request.
      blk0Q <= (doTimeout & gnt0Q) | (blk0Q & bus.req0);
      blk1Q <= (doTimeout & gnt1Q) | (blk1Q & bus.req1);
    end
  end

  always_comb begin
    stateD    = stateQ;
    doGrant   = 1'b0;
    doRelease = 1'b0;
    doTimeout = 1'b0;
    case (stateQ)
      IDLE: begin
        if (bus.m_isReady && (elig0 || elig1)) begin
          stateD  = GRANT;
          doGrant = 1'b1;
        end
      end
      GRANT: begin
        if (!ownerReq) begin
          stateD    = RELEASE;
          doRelease = 1'b1;
        end else if (wdFire) begin
          stateD    = RELEASE;
          doRelease = 1'b1;
          doTimeout = 1'b1;
        end
      end
      RELEASE: begin
        if (bus.m_isReady) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    mStart    = 1'b0;
    mSend     = 1'b0;
    mReceive  = 1'b0;
    mDatasend = 8'h00;
    if (gnt0Q) begin
      mStart    = bus.start0;
      mSend     = bus.send0;
      mReceive  = bus.receive0;
      mDatasend = bus.datasend0;
    end else if (gnt1Q) begin
      mStart    = bus.start1;
      mSend     = bus.send1;
      mReceive  = bus.receive1;
      mDatasend = bus.datasend1;
    end
  end

  assign bus.m_start      = mStart;
  assign bus.m_send       = mSend;
  assign bus.m_receive    = mReceive;
  assign bus.m_datasend   = mDatasend;
  assign bus.gnt0         = gnt0Q;
  assign bus.gnt1         = gnt1Q;
  assign bus.isReady0     = bus.m_isReady & gnt0Q;
  assign bus.isReady1     = bus.m_isReady & gnt1Q;
  assign bus.sended0      = bus.m_sended & gnt0Q;
  assign bus.sended1      = bus.m_sended & gnt1Q;
  assign bus.received0    = bus.m_received & gnt0Q;
  assign bus.received1    = bus.m_received & gnt1Q;
  assign bus.datareceive0 = gnt0Q ? bus.m_datareceive : 8'h00;
  assign bus.datareceive1 = gnt1Q ? bus.m_datareceive : 8'h00;
  assign bus.timeout      = timeoutQ;
  assign bus.state        = stateQ;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: directed scenarios plus random traffic, checked
// every cycle against an ownership-based reference model.
module tb_i2c_bus_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  i2c_bus_arbiter_if bus();

  i2c_bus_arbiter #(.TIMEOUT(16'(TO))) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: who owns the master, how long they have held it, whose turn is next.
  int owner;
  int lastServed;
  int held;
  bit releasing;
  bit toExp;
  bit blk[2];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    owner = -1; lastServed = 1; held = 0; releasing = 0; toExp = 0;
    blk[0] = 0; blk[1] = 0;
  endtask

  task automatic modelEdge();
    bit r[2];
    bit e0, e1;
    r[0] = bus.req0;
    r[1] = bus.req1;
    toExp = 0;
    if (owner >= 0) begin
      held++;
      if (!r[owner]) begin
        lastServed = owner; owner = -1; releasing = 1;
      end else if (held == TO) begin
        blk[owner] = 1; lastServed = owner; owner = -1; releasing = 1; toExp = 1;
      end
    end else if (releasing) begin
      if (bus.m_isReady) releasing = 0;
    end else if (bus.m_isReady) begin
      e0 = r[0] && !blk[0];
      e1 = r[1] && !blk[1];
      if (e0 && e1) owner = 1 - lastServed;
      else if (e0)  owner = 0;
      else if (e1)  owner = 1;
      held = 0;
    end
    for (int n = 0; n < 2; n++) if (!r[n]) blk[n] = 0;
  endtask

  task automatic checkAll();
    bit g0, g1;
    logic [1:0] st;
    g0 = (owner == 0);
    g1 = (owner == 1);
    st = (owner >= 0) ? 2'd1 : (releasing ? 2'd2 : 2'd0);
    checkEq("gnt0", bus.gnt0, g0);
    checkEq("gnt1", bus.gnt1, g1);
    checkEq("state", bus.state, st);
    checkEq("timeout", bus.timeout, toExp);
    checkEq("m_start", bus.m_start, g0 ? bus.start0 : (g1 ? bus.start1 : 1'b0));
    checkEq("m_send", bus.m_send, g0 ? bus.send0 : (g1 ? bus.send1 : 1'b0));
    checkEq("m_receive", bus.m_receive, g0 ? bus.receive0 : (g1 ? bus.receive1 : 1'b0));
    checkEq("m_datasend", bus.m_datasend, g0 ? bus.datasend0 : (g1 ? bus.datasend1 : 8'h00));
    checkEq("isReady0", bus.isReady0, bus.m_isReady & g0);
    checkEq("isReady1", bus.isReady1, bus.m_isReady & g1);
    checkEq("sended0", bus.sended0, bus.m_sended & g0);
    checkEq("sended1", bus.sended1, bus.m_sended & g1);
    checkEq("received0", bus.received0, bus.m_received & g0);
    checkEq("received1", bus.received1, bus.m_received & g1);
    checkEq("datareceive0", bus.datareceive0, g0 ? bus.m_datareceive : 8'h00);
    checkEq("datareceive1", bus.datareceive1, g1 ? bus.m_datareceive : 8'h00);
  endtask

  task automatic cycle();
    #1 checkAll();
    @(posedge clk);
    modelEdge();
    #1 checkAll();
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    #1 checkAll();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic clearInputs();
    bus.req0 = 0; bus.req1 = 0;
    bus.start0 = 0; bus.start1 = 0; bus.send0 = 0; bus.send1 = 0;
    bus.receive0 = 0; bus.receive1 = 0; bus.datasend0 = 8'h00; bus.datasend1 = 8'h00;
    bus.m_isReady = 1; bus.m_sended = 0; bus.m_received = 0; bus.m_datareceive = 8'h00;
  endtask

  int gnt0Cycles;
  int pulses;

  initial begin
    clearInputs();
    reset = 1'b0;
    modelReset();
    #3 checkAll();
    checkEq("rst_state", bus.state, 2'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic grant and data routing
    bus.req0 = 1; bus.datasend0 = 8'hEE; bus.m_datareceive = 8'h55;
    cycle();
    checkEq("t1_gnt0", bus.gnt0, 1'b1);
    checkEq("t1_mdatasend", bus.m_datasend, 8'hEE);
    checkEq("t1_datareceive0", bus.datareceive0, 8'h55);
    checkEq("t1_datareceive1", bus.datareceive1, 8'h00);
    bus.req0 = 0;
    cycle(); cycle();

    // Tie alternation from reset
    resetDut();
    bus.req0 = 1; bus.req1 = 1;
    cycle();
    checkEq("t2_first_gnt0", bus.gnt0, 1'b1);
    bus.req0 = 0; bus.req1 = 0;
    cycle(); cycle();
    bus.req0 = 1; bus.req1 = 1;
    cycle();
    checkEq("t2_second_gnt1", bus.gnt1, 1'b1);
    bus.req0 = 0; bus.req1 = 0;
    cycle(); cycle();

    // Release held off by a busy master
    resetDut();
    bus.req0 = 1;
    cycle();
    bus.req0 = 0; bus.req1 = 1; bus.m_isReady = 0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      checkEq("t3_release_state", bus.state, 2'd2);
      checkEq("t3_no_gnt1", bus.gnt1, 1'b0);
    end
    bus.m_isReady = 1;
    cycle();
    checkEq("t3_idle", bus.state, 2'd0);
    cycle();
    checkEq("t3_gnt1", bus.gnt1, 1'b1);
    bus.req1 = 0;
    cycle(); cycle();

    // Watchdog revocation and blocking
    resetDut();
    bus.req0 = 1; bus.req1 = 1;
    gnt0Cycles = 0; pulses = 0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (bus.gnt0) gnt0Cycles++;
      if (bus.timeout) pulses++;
    end
    checkEq("t4_gnt0_cycles", gnt0Cycles, TO);
    checkEq("t4_pulses", pulses, 1);
    checkEq("t4_gnt1_instead", bus.gnt1, 1'b1);
    bus.req1 = 0;
    cycle(); cycle(); cycle();
    checkEq("t4_blocked", bus.gnt0, 1'b0);
    bus.req0 = 0;
    cycle();
    bus.req0 = 1;
    cycle();
    checkEq("t4_regrant", bus.gnt0, 1'b1);
    bus.req0 = 0;
    cycle(); cycle();

    // Notifications routed only to client 1
    resetDut();
    bus.req1 = 1;
    cycle();
    for (int i = 0; i < 6; i++) begin
      bus.m_sended = i[0]; bus.m_received = i[1];
      cycle();
      checkEq("t5_sended0", bus.sended0, 1'b0);
      checkEq("t5_received0", bus.received0, 1'b0);
      checkEq("t5_sended1", bus.sended1, i[0]);
    end

    // Asynchronous reset while granted
    bus.send1 = 1; bus.m_sended = 0; bus.m_received = 0;
    cycle();
    checkEq("t6_msend_before", bus.m_send, 1'b1);
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkEq("t6_msend", bus.m_send, 1'b0);
    checkEq("t6_gnt1", bus.gnt1, 1'b0);
    checkEq("t6_state", bus.state, 2'd0);
    clearInputs();
    @(negedge clk);
    reset = 1'b1;

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      if (bus.req0) bus.req0 = ($urandom_range(9) != 0);
      else          bus.req0 = ($urandom_range(3) == 0);
      if (bus.req1) bus.req1 = ($urandom_range(9) != 0);
      else          bus.req1 = ($urandom_range(3) == 0);
      bus.m_isReady     = ($urandom_range(3) != 0);
      bus.start0        = $urandom_range(1);
      bus.start1        = $urandom_range(1);
      bus.send0         = $urandom_range(1);
      bus.send1         = $urandom_range(1);
      bus.receive0      = $urandom_range(1);
      bus.receive1      = $urandom_range(1);
      bus.datasend0     = 8'($urandom);
      bus.datasend1     = 8'($urandom);
      bus.m_sended      = $urandom_range(1);
      bus.m_received    = $urandom_range(1);
      bus.m_datareceive = 8'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Two-client arbiter that shares one I2C master transaction port between two byte-level clients, such as the BMP180 sensor sequencer and a second I2C peripheral controller. It grants the master to one client at a time, round-robin, and holds the grant for the client's whole transaction. It multiplexes the client's command signals to the master and routes the master's notifications back to the granted client only. A watchdog forcibly revokes a grant that is held too long.

## Interface
- TIMEOUT, 16'hFFFF, maximum cycles a grant may be held; 0 disables the watchdog.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- req0, req1  in  1  client requests bus; held high for the whole transaction.
- start0, start1  in  1  client start/restart bit.
- send0, send1  in  1  client send enable.
- receive0, receive1  in  1  client receive enable.
- datasend0, datasend1  in  8  client address/data byte.
- gnt0, gnt1  out  1  registered grant; at most one high.
- isReady0, isReady1  out  1  m_isReady & gntN.
- sended0, sended1  out  1  m_sended & gntN.
- received0, received1  out  1  m_received & gntN.
- datareceive0, datareceive1  out  8  m_datareceive if gntN, else 8'h00.
- m_isReady  in  1  master idle/ready for a new transaction.
- m_start, m_send, m_receive  out  1  granted client's start/send/receive, else 0.
- m_datasend  out  8  granted client's datasend, else 8'h00.
- m_sended, m_received  in  1  master byte-sent / byte-received notifications.
- m_datareceive  in  8  master received byte.
- timeout  out  1  one-cycle pulse when the watchdog revokes a grant.
- state  out  2  FSM state code: IDLE=0, GRANT=1, RELEASE=2.

## Operation
- Reset values:
  - state = IDLE; gnt0 = gnt1 = 0; timeout = 0.
  - All m_* outputs are 0; all client outputs are 0.
  - last = 1, so client 0 wins the first tie.
  - Block flags blk0 = blk1 = 0; watchdog count = 0.
- Eligibility: client N is eligible when reqN = 1 and blkN = 0.
- IDLE:
  - Master outputs are forced to 0.
  - If m_isReady = 1 and at least one client is eligible, grant one client and go to GRANT.
  - With one eligible client, grant that client.
  - With two eligible clients, grant the client with index != last.
  - Clear the watchdog count on entry to GRANT.
- GRANT:
  - The granted client's start/send/receive/datasend drive the master combinationally.
  - The master's sended/received/datareceive route to the granted client only.
  - The watchdog count increments every cycle.
  - If the granted client's req = 0, go to RELEASE.
  - Otherwise, if TIMEOUT != 0 and count == TIMEOUT - 1, pulse timeout, set blkN = 1 and go to RELEASE.
  - The granted client dropping req takes priority over a timeout in the same cycle.
- RELEASE:
  - gnt0 = gnt1 = 0 and master outputs are 0.
  - Set last to the index of the client just released.
  - When m_isReady = 1, go to IDLE.
- Block flags: blkN clears in any cycle where reqN = 0, so a timed-out client must drop req before it is eligible again.
- No grant may be given while m_isReady = 0.

## Timing
- Grant latency:
  - Stimulus: req seen at edge k, state IDLE, m_isReady = 1.
  - gnt is high after edge k, so the mux is active from cycle k+1.
- Release:
  - Stimulus: req low at edge k.
  - gnt is low after edge k, state is RELEASE.
  - If m_isReady = 1 at edge k+1, state is IDLE after k+1.
  - Earliest next grant is after edge k+2.
- Timeout: gnt is held for exactly TIMEOUT cycles; timeout is high for the single cycle following the revoking edge.
- Mux paths (client ↔ master) are purely combinational from the registered gnt, with zero added latency.
- A request that drops during IDLE before being granted produces no grant.
- Reset assertion at any time immediately zeroes gnt and all master and client outputs, with no clock needed. An in-flight master transaction is abandoned.

## Test plan
- Reset, then req0 = 1 with m_isReady = 1 → gnt0 = 1 one edge later; datasend0 = 8'hEE appears on m_datasend; m_datareceive = 8'h55 appears on datareceive0; datareceive1 = 8'h00.
- req0 and req1 rise in the same cycle, twice in succession → first grant goes to client 0, second to client 1 (alternation).
- Client 0 is granted and drops req while m_isReady = 0 for 5 cycles → state stays RELEASE for those 5 cycles; req1 is not granted until m_isReady = 1, then one edge after IDLE.
- TIMEOUT = 8 and req0 is held forever → gnt0 high for exactly 8 cycles; timeout pulses once; client 0 is not regranted until req0 goes low and high again; a pending req1 is granted instead.
- While client 1 is granted, toggle m_sended and m_received → only sended1/received1 follow; sended0 = received0 = 0 throughout.
- Assert reset mid-GRANT with m_send = 1 → m_send, gnt1 and state are 0 in the same cycle, before the next clk edge.
